// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream into little-endian
// 32-bit words and writes them to consecutive word addresses, holding the core meanwhile.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [15:0]       r_count;
  logic [ADDR_W:0]   r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_asm;

  logic              w_accept;
  logic [15:0]       w_len;
  logic              w_last;

  assign w_accept = i_in_valid && o_in_ready;
  assign w_len    = {i_in_data, r_count[7:0]};
  // word_idx is one bit wider than the address so N == DEPTH is representable.
  assign w_last   = (16'(r_word_idx) + 16'd1) == r_count;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (i_start) begin
            r_state    <= S_LEN_LO;
            r_word_idx <= '0;
            r_byte_idx <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_count[7:0] <= i_in_data;
            r_state      <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_count[15:8] <= i_in_data;
            if (w_len == 16'd0)
              r_state <= S_DONE;
            else if ({1'b0, w_len} > 17'(DEPTH))
              r_state <= S_ERR;
            else
              r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_asm[{r_byte_idx, 3'b000} +: 8] <= i_in_data;
            r_byte_idx                       <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3)
              r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_word_idx <= r_word_idx + 1'b1;
          r_state    <= w_last ? S_DONE : S_DATA;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; nothing combinational from i_in_valid or i_start.
  assign o_in_ready  = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
  assign o_mem_we    = (r_state == S_WRITE);
  assign o_mem_addr  = r_word_idx[ADDR_W-1:0];
  assign o_mem_wdata = r_asm;
  assign o_cpu_hold  = !((r_state == S_IDLE) || (r_state == S_DONE));
  assign o_done      = (r_state == S_DONE);
  assign o_error     = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader: a frame-level model derives the expected
// memory writes, and a monitor collects what the loader actually wrote.
module tb_imem_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, mem_we, cpu_hold, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_cpu_hold(cpu_hold), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  wr_t        act_q[$];
  wr_t        exp_q[$];
  logic [7:0] frame[$];
  int         acc_edge[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         hold_err = 0;
  int         timeouts = 0;
  int         vectors = 0;
  int         miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) act_q.push_back(wr_t'{mem_addr, mem_wdata, cyc});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if ((mem_we && !cpu_hold) || (done && cpu_hold)) hold_err++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Expected writes from the frame rules alone: N words, each {b3,b2,b1,b0}.
  task automatic model();
    int n;
    exp_q.delete();
    n = {frame[1], frame[0]};
    if (n != 0 && n <= DEPTH) begin
      for (int w = 0; w < n; w++) begin
        logic [ADDR_W-1:0] a;
        a = w[ADDR_W-1:0];
        exp_q.push_back(wr_t'{a, {frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]}, 0});
      end
    end
  endtask

  task automatic build_frame(input int n, input int words);
    logic [15:0] len;
    len = n[15:0];
    frame.delete();
    frame.push_back(len[7:0]);
    frame.push_back(len[15:8]);
    for (int i = 0; i < 4 * words; i++) frame.push_back(8'($urandom));
  endtask

  // Present each byte until accepted; optional random idle gaps with in_valid low.
  task automatic send_frame(input bit gaps);
    for (int i = 0; i < frame.size(); i++) begin
      int  n;
      bit  acc;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = frame[i];
      n = 0;
      forever begin
        acc = in_ready;
        if (!cpu_hold) hold_err++;
        step();
        if (acc) begin
          acc_edge.push_back(cyc);
          break;
        end
        n++;
        if (n > 20) begin
          timeouts++;
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 50 && done_cnt < target; i++) step();
    if (done_cnt < target) timeouts++;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_addr"}, act_q[i].addr, exp_q[i].addr);
      check({tag, "_data"}, act_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic new_load();
    act_q.delete();
    acc_edge.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;

    // Reset with start and valid asserted: rst wins, nothing accepted.
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    step(); step();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 0);
    check("post_rst_writes", act_q.size(), 0);

    // Two-word load, back-to-back bytes.
    new_load();
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h83, 8'h31, 8'h00, 8'h00};
    model();
    d0 = done_cnt;
    pulse_start();
    check("start_in_ready", in_ready, 1);
    check("start_cpu_hold", cpu_hold, 1);
    send_frame(1'b0);
    wait_done(d0 + 1);
    compare_writes("two_word");
    if (act_q.size() == 2) begin
      check("two_word_w1_data", act_q[1].data, 32'h0000_3183);
      check("two_word_we_latency", act_q[0].cyc, acc_edge[5]);
      check("two_word_done_cycle", done_cyc, act_q[1].cyc + 1);
    end
    check("two_word_idle_hold", cpu_hold, 0);
    check("two_word_idle_ready", in_ready, 0);
    step(); step();
    check("two_word_done_once", done_cnt - d0, 1);

    // Zero length frame.
    new_load();
    frame = '{8'h00, 8'h00};
    model();
    d0 = done_cnt;
    pulse_start();
    send_frame(1'b0);
    wait_done(d0 + 1);
    check("zero_writes", act_q.size(), 0);
    check("zero_done_cycle", done_cyc, acc_edge[1]);
    check("zero_hold_after", cpu_hold, 0);

    // Overflow N = 257, then recovery with a random one-word load.
    new_load();
    frame = '{8'h01, 8'h01};
    d0 = done_cnt;
    pulse_start();
    send_frame(1'b0);
    in_valid = 1'b1;
    step(); step(); step();
    in_valid = 1'b0;
    check("ovf_error", error, 1);
    check("ovf_hold", cpu_hold, 1);
    check("ovf_in_ready", in_ready, 0);
    check("ovf_writes", act_q.size(), 0);
    check("ovf_no_done", done_cnt, d0);
    build_frame(1, 1);
    model();
    pulse_start();
    check("ovf_error_cleared", error, 0);
    check("ovf_restart_ready", in_ready, 1);
    send_frame(1'b0);
    wait_done(d0 + 1);
    compare_writes("ovf_recover");

    // Full-depth load with random valid gaps.
    new_load();
    build_frame(DEPTH, DEPTH);
    model();
    d0 = done_cnt;
    pulse_start();
    send_frame(1'b1);
    wait_done(d0 + 1);
    compare_writes("full");
    if (act_q.size() > 0) check("full_last_addr", act_q[act_q.size()-1].addr, DEPTH - 1);

    // Reset after two payload bytes drops the partial word.
    new_load();
    frame = '{8'h01, 8'h00, 8'h13, 8'h00};
    pulse_start();
    send_frame(1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_hold", cpu_hold, 0);
    repeat (6) step();
    check("midrst_writes", act_q.size(), 0);
    new_load();
    frame = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    model();
    d0 = done_cnt;
    pulse_start();
    send_frame(1'b0);
    wait_done(d0 + 1);
    compare_writes("midrst_reload");
    if (act_q.size() == 1) begin
      check("midrst_reload_addr", act_q[0].addr, 0);
      check("midrst_reload_data", act_q[0].data, 32'h0000_0013);
    end

    check("hold_violations", hold_err, 0);
    check("timeouts", timeouts, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory writer for the pipelined core. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each completed word goes to the instruction memory write port at consecutive word addresses from 0, the same word-indexed memory that fetch reads at pc >> 2. While a load is in progress it holds the pipeline through `cpu_hold`; the top level ANDs `~cpu_hold` into `pc_write`.

## Interface
Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words
- ADDR_W, 8, word-address width (log2 DEPTH)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a load; sampled only in IDLE or ERR
- in_valid  in  1  byte source has data
- in_data  in  8  byte payload
- in_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_addr  out  ADDR_W  word address (not byte address)
- mem_wdata  out  32  instruction word
- cpu_hold  out  1  pipeline hold; high while a load is active or failed
- done  out  1  one-cycle pulse after the final word is written
- error  out  1  frame length exceeded DEPTH; sticky until start or rst

## Operation
- Byte accepted iff in_valid && in_ready in the same cycle. No other condition consumes a byte.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4N payload bytes. Each word is sent LSB first: bytes b0..b3 form {b3,b2,b1,b0}.
- States:
  - IDLE: in_ready=0. start → LEN_LO.
  - LEN_LO: in_ready=1. On accept, store N[7:0] → LEN_HI.
  - LEN_HI: in_ready=1. On accept, store N[15:8]. Then: N==0 → DONE; N>DEPTH → ERR; else → DATA.
  - DATA: in_ready=1. Accepted byte goes into assembly register lane byte_idx, and byte_idx increments mod 4. Accepting lane 3 → WRITE.
  - WRITE: in_ready=0, mem_we=1, mem_addr=word_idx, mem_wdata=assembled word. word_idx increments. If word_idx was N-1 → DONE, else → DATA.
  - DONE: done=1 for exactly one cycle → IDLE.
  - ERR: in_ready=0, error=1. start → LEN_LO (error clears the same edge).
- cpu_hold=1 in LEN_LO, LEN_HI, DATA, WRITE and ERR. It is 0 in IDLE and DONE.
- Widths:
  - Word count register is 16 bits.
  - word_idx is ADDR_W+1 bits, so DEPTH=256 with N=256 is legal and writes address 255 last.
  - Comparison N>DEPTH is unsigned.
- start is ignored in every state except IDLE and ERR. in_valid is ignored outside states with in_ready=1.
- Each new load restarts at word address 0 and byte_idx 0. The assembly register is not cleared between words; all four lanes are overwritten before each write.
- The loader never reads memory and never writes an address ≥ N.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 0, done 0, error 0. Internal word_idx, byte_idx, count and assembly register are all 0.
- mem_we, mem_addr, mem_wdata, done, error, cpu_hold and in_ready are decoded from registered state and registered datapath only. There are no combinational paths from in_valid or start to any output.
- Latency:
  - start edge → in_ready high next cycle.
  - Accept of byte 3 of a word → mem_we high the following cycle.
  - Minimum throughput is 5 cycles per word (4 accepts + 1 WRITE).
- Last WRITE → done pulse in the next cycle → IDLE the cycle after. cpu_hold falls in the DONE cycle.
- Backpressure: a byte presented during WRITE stays pending and is consumed in the first DATA cycle. in_valid gaps stall without side effects.
- rst mid-load: returns to IDLE at the next edge. Any partial word is dropped, and no mem_we is issued for it.
- start asserted in the same cycle as rst: rst wins.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 and start=1 → all outputs 0, no byte accepted.
- Two-word load: start, then bytes 02 00 13 00 00 00 83 31 00 00 sent back-to-back →
  - mem_we (addr 0, 0x00000013), then mem_we (addr 1, 0x00003183).
  - Exactly 2 writes; done pulses once, 1 cycle after the second write.
  - cpu_hold is high from LEN_LO through the second WRITE.
- Zero length: start, bytes 00 00 → no mem_we, done pulse the cycle after LEN_HI accept, cpu_hold low after.
- Overflow: start, bytes 01 01 (N=257) → error=1, cpu_hold=1, in_ready=0, no writes. A subsequent start clears error, and a 1-word load then writes address 0.
- Boundary and backpressure: N=256, in_valid randomly toggled, valid held through WRITE cycles →
  - 256 writes to addresses 0..255 with correct data.
  - No byte lost or duplicated; last address is 255.
- Reset mid-load: rst after 2 payload bytes of word 0 → no mem_we. A fresh 1-word load of 0x00000013 then writes address 0 with 0x00000013.
